msp430_evt_sync_sched: RTL and testbench
========================================

MSP430_EVT_SYNC_SCHED -- requirements
Module: msp430_evt_sync_sched

Interface
REQ-001 Parameter NUM_SRC, default 4, number of asynchronous event sources (2..8).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per source (>=2).
REQ-003 clk  input  1  receiving clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
REQ-005 evt_in  input  NUM_SRC  asynchronous event lines; a rising edge is one event.
REQ-006 src_en  input  NUM_SRC  per-source enable, synchronous to clk.
REQ-007 evt_ack  input  1  consumer accepts the offered event.
REQ-008 ovf_clr  input  1  single-cycle pulse; clears all overflow flags.
REQ-009 evt_valid  output  1  an event is being offered.
REQ-010 evt_id  output  clog2(NUM_SRC)  index of the offered source.
REQ-011 evt_pend  output  NUM_SRC  pending-event status vector.
REQ-012 evt_ovf  output  NUM_SRC  sticky per-source overflow flags.

Function
REQ-013 Each evt_in[i] SHALL pass through a SYNC_STAGES-deep flop chain; only the final stage feeds logic.
REQ-014 A prev register per source SHALL hold the last synchronized value; rise[i] = sync[i] & ~prev[i].
REQ-015 With src_en[i]=1, rise[i] SHALL set pend[i] on the next edge.
REQ-016 With src_en[i]=0, rise[i] SHALL be ignored and pend[i] SHALL be cleared on the next edge.
REQ-017 If rise[i] occurs while pend[i]=1 and src_en[i]=1, ovf[i] SHALL be set; pend[i] stays 1 (events merge).
REQ-018 ovf SHALL clear only on ovf_clr; if ovf_clr coincides with a new overflow, the set wins.
REQ-019 FSM states: IDLE and OFFER.
REQ-020 IDLE: if any pend&src_en bit is set, the FSM SHALL select a source round-robin starting at rr_ptr, register it in evt_id, assert evt_valid on the next edge, and enter OFFER.
REQ-021 OFFER: evt_valid and evt_id SHALL hold stable until evt_ack=1, regardless of src_en changes.
REQ-022 On the evt_ack edge in OFFER: clear pend[evt_id], set rr_ptr=(evt_id+1) mod NUM_SRC, deassert evt_valid, and return to IDLE.
REQ-023 A rise on the acknowledged source in the ack cycle SHALL win over the clear; pend stays 1 and ovf is not set.
REQ-024 evt_ack SHALL be ignored in IDLE.
REQ-025 evt_valid SHALL be low for at least one cycle between consecutive offers.
REQ-026 Latency: with evt_in first sampled high at edge 1 and the FSM idle, evt_valid SHALL rise at edge SYNC_STAGES+2 (edge 4 at default).
REQ-027 evt_pend SHALL equal the pend register directly; evt_ovf SHALL equal the ovf register directly.

Reset
REQ-028 rst_n low SHALL asynchronously clear sync chains, prev, pend, ovf, and rr_ptr, and force FSM=IDLE, evt_valid=0, evt_id=0.
REQ-029 Reset asserted during OFFER SHALL drop evt_valid immediately without acknowledgement; the offered event is lost.
REQ-030 An evt_in held high through reset release SHALL produce exactly one event after synchronization.

Verification
REQ-031 Single event: evt_in[2] 0->1, src_en=all ones -> evt_valid=1, evt_id=2 at edge 4; ack -> pend[2]=0 and evt_valid=0 on the next edge.
REQ-032 Round-robin: evt_in[0], [1], and [3] rise together with immediate acks -> grant order 0, 1, 3; after a new rise on 0, the next grant is 0 once rr_ptr has wrapped.
REQ-033 Overflow: two rises on source 1 without an ack -> one offer, evt_ovf[1]=1; ovf_clr pulse -> evt_ovf=0.
REQ-034 Masking: src_en[3]=0 with a rise on evt_in[3] -> no offer and pend[3]=0; src_en[3] dropped during OFFER of source 3 -> evt_valid held until ack.
REQ-035 Collision: a rise on the offered source in the evt_ack cycle -> pend stays 1, the source is re-offered after one idle cycle, and evt_ovf is unchanged.
REQ-036 Reset mid-OFFER: rst_n low -> evt_valid=0 asynchronously, all outputs 0; after release, a held-high input generates one event.

Source files
------------

// File: rtl/msp430_evt_sync_sched_if.sv
// rtl/msp430_evt_sync_sched_if.sv - event lines, offer handshake and status bundle for the event scheduler
interface msp430_evt_sync_sched_if #(
    parameter int NUM_SRC = 4
);
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] evt_in;
    logic [NUM_SRC-1:0] src_en;
    logic               evt_ack;
    logic               ovf_clr;
    logic               evt_valid;
    logic [ID_W-1:0]    evt_id;
    logic [NUM_SRC-1:0] evt_pend;
    logic [NUM_SRC-1:0] evt_ovf;

    modport master (
        output evt_in,
        output src_en,
        output evt_ack,
        output ovf_clr,
        input  evt_valid,
        input  evt_id,
        input  evt_pend,
        input  evt_ovf
    );

    modport slave (
        input  evt_in,
        input  src_en,
        input  evt_ack,
        input  ovf_clr,
        output evt_valid,
        output evt_id,
        output evt_pend,
        output evt_ovf
    );
endinterface

// File: rtl/msp430_evt_sync_sched.sv
// rtl/msp430_evt_sync_sched.sv - async event synchronizer with pending/overflow tracking and round-robin offer FSM
module msp430_evt_sync_sched #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    msp430_evt_sync_sched_if.slave bus
);
    localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t state_q, state_nxt;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] sync_out;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_q, pend_nxt;
    logic [NUM_SRC-1:0] ovf_q, ovf_nxt;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] req;
    logic [ID_W-1:0]    id_q, id_nxt;
    logic [ID_W-1:0]    rr_q, rr_nxt;

    // First requester at or after the round-robin pointer; scanning downward
    // lets the lowest offset overwrite the others.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                                input logic [ID_W-1:0]    p);
        logic [ID_W-1:0] sel;
        int              c;
        sel = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            c = int'(p) + k;
            if (c >= NUM_SRC) c = c - NUM_SRC;
            if (r[c]) sel = ID_W'(c);
        end
        return sel;
    endfunction

    // Only the last synchronizer stage is allowed to reach downstream logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.evt_in};
            prev_q <= sync_out;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;

    // A fresh rise beats an acknowledge clear on the same source and is not
    // treated as an overflow, since the earlier event is being consumed.
    always_comb begin
        pend_nxt = pend_q;
        ovf_nxt  = ovf_q;
        if (bus.ovf_clr) ovf_nxt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!bus.src_en[i]) begin
                pend_nxt[i] = 1'b0;
            end else if (rise[i]) begin
                pend_nxt[i] = 1'b1;
                if (pend_q[i] && !ack_clr[i]) ovf_nxt[i] = 1'b1;
            end else if (ack_clr[i]) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        id_nxt    = id_q;
        rr_nxt    = rr_q;
        ack_clr   = '0;
        req       = pend_q & bus.src_en;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    id_nxt    = rr_pick(req, rr_q);
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                // Offer is frozen until acknowledged, even if the source is disabled.
                if (bus.evt_ack) begin
                    ack_clr[id_q] = 1'b1;
                    if (int'(id_q) == NUM_SRC - 1) rr_nxt = '0;
                    else                           rr_nxt = id_q + 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            rr_q    <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_nxt;
            id_q    <= id_nxt;
            rr_q    <= rr_nxt;
            pend_q  <= pend_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    assign bus.evt_valid = (state_q == OFFER);
    assign bus.evt_id    = id_q;
    assign bus.evt_pend  = pend_q;
    assign bus.evt_ovf   = ovf_q;

endmodule

// File: tb/tb_msp430_evt_sync_sched.sv
// tb/tb_msp430_evt_sync_sched.sv - scoreboard bench for the event synchronizer/scheduler
module tb_msp430_evt_sync_sched;
    localparam int NUM_SRC     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ID_W        = $clog2(NUM_SRC);

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   exp_q[$];

    msp430_evt_sync_sched_if #(.NUM_SRC(NUM_SRC)) ifc ();

    msp430_evt_sync_sched #(.NUM_SRC(NUM_SRC), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_offer(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ifc.evt_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack;
        ifc.evt_ack = 1'b1;
        @(negedge clk);
        ifc.evt_ack = 1'b0;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ifc.evt_in = '0; ifc.src_en = '1; ifc.evt_ack = 1'b0; ifc.ovf_clr = 1'b0;
        cycles(2);
        checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ifc.evt_valid); end
        checks++; if (ifc.evt_id !== '0) begin failures++; $display("FAIL reset_id got=%0d exp=0", ifc.evt_id); end
        checks++; if (ifc.evt_pend !== '0) begin failures++; $display("FAIL reset_pend got=%b exp=0000", ifc.evt_pend); end
        checks++; if (ifc.evt_ovf !== '0) begin failures++; $display("FAIL reset_ovf got=%b exp=0000", ifc.evt_ovf); end
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_single;
        int exp;
        ifc.evt_in[2] = 1'b1; exp_q.push_back(2);
        cycles(3);
        checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0b exp=0", ifc.evt_valid); end
        checks++; if (ifc.evt_pend !== 4'b0100) begin failures++; $display("FAIL single_pend got=%b exp=0100", ifc.evt_pend); end
        cycles(1);
        checks++; if (ifc.evt_valid !== 1'b1) begin failures++; $display("FAIL single_latency_valid got=%0b exp=1", ifc.evt_valid); end
        exp = exp_q.pop_front();
        checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL single_id got=%0d exp=%0d", ifc.evt_id, exp); end
        pulse_ack;
        checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL single_ack_valid got=%0b exp=0", ifc.evt_valid); end
        checks++; if (ifc.evt_pend[2] !== 1'b0) begin failures++; $display("FAIL single_ack_pend got=%0b exp=0", ifc.evt_pend[2]); end
        ifc.evt_in[2] = 1'b0;
        cycles(4);
    endtask

    task automatic test_round_robin;
        bit ok;
        int exp;
        apply_reset;
        ifc.evt_in = 4'b1011;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        for (int n = 0; n < 3; n++) begin
            wait_offer(ok);
            checks++; if (!ok) begin failures++; $display("FAIL rr_timeout grant=%0d got=0 exp=1", n); end
            if (ok) begin
                exp = exp_q.pop_front();
                checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL rr_order grant=%0d got=%0d exp=%0d", n, ifc.evt_id, exp); end
                pulse_ack;
                checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL rr_gap grant=%0d got=%0b exp=0", n, ifc.evt_valid); end
            end
        end
        checks++; if (ifc.evt_pend !== 4'b0000) begin failures++; $display("FAIL rr_pend_drained got=%b exp=0000", ifc.evt_pend); end
        ifc.evt_in = '0;
        cycles(4);
        ifc.evt_in[0] = 1'b1; exp_q.push_back(0);
        wait_offer(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rr_wrap_timeout got=0 exp=1"); end
        if (ok) begin
            exp = exp_q.pop_front();
            checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL rr_wrap_id got=%0d exp=%0d", ifc.evt_id, exp); end
            pulse_ack;
        end
        ifc.evt_in = '0;
        cycles(4);
    endtask

    task automatic test_overflow;
        bit ok;
        int exp;
        ifc.evt_in[1] = 1'b1; exp_q.push_back(1);
        wait_offer(ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got=0 exp=1"); end
        exp = exp_q.pop_front();
        checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL ovf_id got=%0d exp=%0d", ifc.evt_id, exp); end
        ifc.evt_in[1] = 1'b0; cycles(3);
        ifc.evt_in[1] = 1'b1; cycles(4);
        checks++; if (ifc.evt_ovf !== 4'b0010) begin failures++; $display("FAIL ovf_set got=%b exp=0010", ifc.evt_ovf); end
        checks++; if (ifc.evt_valid !== 1'b1 || ifc.evt_pend[1] !== 1'b1) begin failures++; $display("FAIL ovf_merge got=%0b%0b exp=11", ifc.evt_valid, ifc.evt_pend[1]); end
        // Third rise lands in the same cycle as the clear pulse.
        ifc.evt_in[1] = 1'b0; cycles(3);
        ifc.evt_in[1] = 1'b1; cycles(2);
        ifc.ovf_clr = 1'b1; cycles(1); ifc.ovf_clr = 1'b0;
        checks++; if (ifc.evt_ovf !== 4'b0010) begin failures++; $display("FAIL ovf_set_wins got=%b exp=0010", ifc.evt_ovf); end
        pulse_ack;
        checks++; if (ifc.evt_pend !== 4'b0000) begin failures++; $display("FAIL ovf_ack_pend got=%b exp=0000", ifc.evt_pend); end
        cycles(5);
        checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_single_offer got=%0b exp=0", ifc.evt_valid); end
        ifc.ovf_clr = 1'b1; cycles(1); ifc.ovf_clr = 1'b0;
        checks++; if (ifc.evt_ovf !== 4'b0000) begin failures++; $display("FAIL ovf_clr got=%b exp=0000", ifc.evt_ovf); end
        ifc.evt_in[1] = 1'b0;
        cycles(4);
    endtask

    task automatic test_masking;
        bit ok;
        int exp;
        ifc.src_en = 4'b0111;
        ifc.evt_in[3] = 1'b1;
        cycles(6);
        checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL mask_no_offer got=%0b exp=0", ifc.evt_valid); end
        checks++; if (ifc.evt_pend !== 4'b0000) begin failures++; $display("FAIL mask_pend got=%b exp=0000", ifc.evt_pend); end
        ifc.evt_in[3] = 1'b0; cycles(3);
        ifc.src_en = '1;
        ifc.evt_in[3] = 1'b1; exp_q.push_back(3);
        wait_offer(ok);
        checks++; if (!ok) begin failures++; $display("FAIL mask_timeout got=0 exp=1"); end
        exp = exp_q.pop_front();
        checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL mask_id got=%0d exp=%0d", ifc.evt_id, exp); end
        ifc.src_en[3] = 1'b0;
        cycles(2);
        checks++; if (ifc.evt_valid !== 1'b1 || ifc.evt_id !== 2'd3) begin failures++; $display("FAIL mask_hold got=%0b/%0d exp=1/3", ifc.evt_valid, ifc.evt_id); end
        checks++; if (ifc.evt_pend[3] !== 1'b0) begin failures++; $display("FAIL mask_disabled_pend got=%0b exp=0", ifc.evt_pend[3]); end
        pulse_ack;
        checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL mask_ack_valid got=%0b exp=0", ifc.evt_valid); end
        ifc.src_en = '1;
        ifc.evt_in[3] = 1'b0;
        cycles(4);
    endtask

    task automatic test_collision;
        bit ok;
        int exp;
        ifc.evt_in[0] = 1'b1; exp_q.push_back(0);
        wait_offer(ok);
        checks++; if (!ok) begin failures++; $display("FAIL coll_timeout got=0 exp=1"); end
        exp = exp_q.pop_front();
        checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL coll_id got=%0d exp=%0d", ifc.evt_id, exp); end
        ifc.evt_in[0] = 1'b0; cycles(3);
        // Rise reaches the edge detector in exactly the acknowledge cycle.
        ifc.evt_in[0] = 1'b1; exp_q.push_back(0); cycles(2);
        ifc.evt_ack = 1'b1; cycles(1); ifc.evt_ack = 1'b0;
        checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL coll_idle_gap got=%0b exp=0", ifc.evt_valid); end
        checks++; if (ifc.evt_pend[0] !== 1'b1) begin failures++; $display("FAIL coll_pend got=%0b exp=1", ifc.evt_pend[0]); end
        checks++; if (ifc.evt_ovf !== 4'b0000) begin failures++; $display("FAIL coll_ovf got=%b exp=0000", ifc.evt_ovf); end
        cycles(1);
        checks++; if (ifc.evt_valid !== 1'b1) begin failures++; $display("FAIL coll_reoffer got=%0b exp=1", ifc.evt_valid); end
        exp = exp_q.pop_front();
        checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL coll_reoffer_id got=%0d exp=%0d", ifc.evt_id, exp); end
        pulse_ack;
        ifc.evt_in[0] = 1'b0;
        cycles(4);
    endtask

    task automatic test_reset_mid_offer;
        bit ok;
        int exp;
        int extra;
        ifc.evt_in[2] = 1'b1; exp_q.push_back(2);
        wait_offer(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_offer_timeout got=0 exp=1"); end
        exp = exp_q.pop_front();
        checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL rst_offer_id got=%0d exp=%0d", ifc.evt_id, exp); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ifc.evt_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0b exp=0", ifc.evt_valid); end
        checks++; if (ifc.evt_id !== '0 || ifc.evt_pend !== '0 || ifc.evt_ovf !== '0) begin failures++; $display("FAIL rst_async_outs got=%0d/%b/%b exp=0/0000/0000", ifc.evt_id, ifc.evt_pend, ifc.evt_ovf); end
        cycles(2);
        rst_n = 1'b1; exp_q.push_back(2);
        wait_offer(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_held_timeout got=0 exp=1"); end
        if (ok) begin
            exp = exp_q.pop_front();
            checks++; if (ifc.evt_id !== ID_W'(exp)) begin failures++; $display("FAIL rst_held_id got=%0d exp=%0d", ifc.evt_id, exp); end
            pulse_ack;
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (ifc.evt_valid === 1'b1) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL rst_held_single got=%0d exp=0", extra); end
        ifc.evt_in[2] = 1'b0;
        cycles(2);
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_overflow;
        test_masking;
        test_collision;
        test_reset_mid_offer;
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
